// File: rtl/traffic_sequencer.sv
// traffic_sequencer: four-way intersection light sequencer timed by Timer ticks, with latched pedestrian walk phase.
module traffic_sequencer #(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 2,
  parameter int RED_TICKS    = 1,
  parameter int WALK_TICKS   = 4,
  parameter int CW           = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       t,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_pending,
  output logic       timer_reset,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5,
    WALK      = 3'd6,
    ILLEGAL   = 3'd7
  } state_e;
  localparam logic [CW-1:0] G_LAST = CW'(GREEN_TICKS - 1);
  localparam logic [CW-1:0] Y_LAST = CW'(YELLOW_TICKS - 1);
  localparam logic [CW-1:0] R_LAST = CW'(RED_TICKS - 1);
  localparam logic [CW-1:0] W_LAST = CW'(WALK_TICKS - 1);
  state_e        state_q, state_d, state_nxt;
  logic [CW-1:0] cnt_q, cnt_d, last;
  logic          ped_q, ped_d, tr_q, tr_d;
  logic          accept, adv;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RED_B;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      tr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      tr_q    <= tr_d;
    end
  end
  // Ticks landing in the restart cycle belong to the previous Timer interval, so they are dropped.
  always_comb begin
    last      = (state_q == NS_GREEN || state_q == EW_GREEN) ? G_LAST :
                (state_q == NS_YELLOW || state_q == EW_YELLOW) ? Y_LAST :
                (state_q == WALK) ? W_LAST : R_LAST;
    accept    = t && !tr_q;
    adv       = (accept && cnt_q == last) || state_q == ILLEGAL;
    state_nxt = (state_q == RED_B) ? (ped_q ? WALK : NS_GREEN) :
                (state_q == WALK) ? NS_GREEN :
                (state_q == ILLEGAL) ? RED_B : state_e'(state_q + 3'd1);
    state_d   = adv ? state_nxt : state_q;
    cnt_d     = adv ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    ped_d     = (adv && state_q == RED_B && ped_q) ? 1'b0 :
                (ped_req && state_q != WALK) ? 1'b1 : ped_q;
    tr_d      = adv;
  end
  always_comb begin
    ns_light    = (state_q == NS_GREEN) ? 3'b001 : (state_q == NS_YELLOW) ? 3'b010 : 3'b100;
    ew_light    = (state_q == EW_GREEN) ? 3'b001 : (state_q == EW_YELLOW) ? 3'b010 : 3'b100;
    walk        = state_q == WALK;
    ped_pending = ped_q;
    timer_reset = tr_q;
    phase       = state_q;
  end
endmodule

// File: tb/tb_traffic_sequencer.sv
// tb_traffic_sequencer: directed scenarios for traffic_sequencer with a cycle-level reference model.
module tb_traffic_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0, t = 1'b0, ped_req = 1'b0, t2 = 1'b0, ped2 = 1'b0;
  logic [2:0] ns_light, ew_light, phase, ns2, ew2, phase2;
  logic walk, ped_pending, timer_reset, walk2, pend2, tr2;
  int checks = 0, errors = 0;
  int m_ph, m_cnt, d_cyc;
  bit m_tr, m_pend;
  int lg[$], plen[$];
  int dur[7] = '{8, 2, 1, 8, 2, 1, 4};
  logic [2:0] ns_t[7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_t[7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

  always #5 clock = ~clock;

  traffic_sequencer dut (
    .clock(clock), .reset(reset), .t(t), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .walk(walk),
    .ped_pending(ped_pending), .timer_reset(timer_reset), .phase(phase)
  );

  traffic_sequencer #(.GREEN_TICKS(1), .RED_TICKS(16), .CW(4)) dut2 (
    .clock(clock), .reset(reset), .t(t2), .ped_req(ped2),
    .ns_light(ns2), .ew_light(ew2), .walk(walk2),
    .ped_pending(pend2), .timer_reset(tr2), .phase(phase2)
  );

  task automatic model_reset();
    m_ph = 5; m_cnt = 0; m_tr = 1'b1; m_pend = 1'b0; d_cyc = 0;
  endtask

  // Drive one clock of stimulus, advance the reference model, and compare every output.
  task automatic cycle(input bit tv, input bit pr);
    bit acc, adv;
    int nxt;
    logic [2:0] pb;
    pb = phase;
    t = tv; ped_req = pr;
    acc = tv && !m_tr;
    adv = acc && (m_cnt == dur[m_ph] - 1);
    nxt = (m_ph == 5) ? (m_pend ? 6 : 0) : (m_ph == 6) ? 0 : m_ph + 1;
    if (adv && m_ph == 5 && m_pend) m_pend = 1'b0;
    else if (pr && m_ph != 6) m_pend = 1'b1;
    m_cnt = adv ? 0 : acc ? m_cnt + 1 : m_cnt;
    if (adv) m_ph = nxt;
    m_tr = adv;
    @(posedge clock); #1;
    d_cyc++;
    if (phase !== pb) begin lg.push_back(int'(phase)); plen.push_back(d_cyc); d_cyc = 0; end
    checks += 6;
    if (phase !== 3'(m_ph)) begin errors++; $display("FAIL phase: got %0d want %0d", phase, m_ph); end
    if (timer_reset !== m_tr) begin errors++; $display("FAIL timer_reset: got %b want %b (phase %0d)", timer_reset, m_tr, m_ph); end
    if (ped_pending !== m_pend) begin errors++; $display("FAIL ped_pending: got %b want %b (phase %0d)", ped_pending, m_pend, m_ph); end
    if (ns_light !== ns_t[m_ph]) begin errors++; $display("FAIL ns_light: got %b want %b", ns_light, ns_t[m_ph]); end
    if (ew_light !== ew_t[m_ph]) begin errors++; $display("FAIL ew_light: got %b want %b", ew_light, ew_t[m_ph]); end
    if (walk !== (m_ph == 6)) begin errors++; $display("FAIL walk: got %b want %b", walk, m_ph == 6); end
  endtask

  // pmode: 0 no request, 1 single pulse during EW_GREEN, 2 request held high.
  task automatic run(input int ntrans, input int period, input int pmode);
    bit pulsed, pr;
    lg.delete(); plen.delete(); d_cyc = 0; pulsed = 1'b0;
    for (int k = 0; k < 3000 && lg.size() < ntrans; k++) begin
      pr = (pmode == 2) || (pmode == 1 && !pulsed && m_ph == 3);
      if (pmode == 1 && pr) pulsed = 1'b1;
      cycle((k % period) == 0, pr);
    end
    ped_req = 1'b0; t = 1'b0;
    checks++;
    if (lg.size() < ntrans) begin errors++; $display("FAIL run timeout: got %0d transitions want %0d", lg.size(), ntrans); end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (phase !== 3'd5) begin errors++; $display("FAIL reset phase: got %0d want 5", phase); end
    if (ns_light !== 3'b100 || ew_light !== 3'b100) begin errors++; $display("FAIL reset lamps: got %b/%b want 100/100", ns_light, ew_light); end
    if (walk !== 1'b0) begin errors++; $display("FAIL reset walk: got %b want 0", walk); end
    if (ped_pending !== 1'b0) begin errors++; $display("FAIL reset ped_pending: got %b want 0", ped_pending); end
    if (timer_reset !== 1'b1) begin errors++; $display("FAIL reset timer_reset: got %b want 1", timer_reset); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b1, 1'b0);
    checks += 2;
    if (timer_reset !== 1'b0) begin errors++; $display("FAIL release timer_reset: got %b want 0", timer_reset); end
    if (phase !== 3'd5) begin errors++; $display("FAIL release phase: got %0d want 5", phase); end
  endtask

  task automatic test_sequence();
    int exp[7] = '{0, 1, 2, 3, 4, 5, 0};
    run(7, 4, 0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= lg.size() || lg[i] != exp[i]) begin errors++; $display("FAIL sequence[%0d]: got %0d want %0d", i, (i < lg.size()) ? lg[i] : -1, exp[i]); end
    end
  endtask

  task automatic test_ped_walk();
    int exp[7] = '{1, 2, 3, 4, 5, 6, 0};
    run(7, 4, 1);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (i >= lg.size() || lg[i] != exp[i]) begin errors++; $display("FAIL ped_walk[%0d]: got %0d want %0d", i, (i < lg.size()) ? lg[i] : -1, exp[i]); end
    end
  endtask

  task automatic test_ped_hold();
    int exp[14] = '{1, 2, 3, 4, 5, 6, 0, 1, 2, 3, 4, 5, 6, 0};
    run(14, 1, 2);
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (i >= lg.size() || lg[i] != exp[i]) begin errors++; $display("FAIL ped_hold[%0d]: got %0d want %0d", i, (i < lg.size()) ? lg[i] : -1, exp[i]); end
    end
  endtask

  // With t stuck high each phase lasts its ticks plus the ignored restart cycle.
  task automatic test_tick_ignore();
    int exp[7] = '{1, 2, 3, 4, 5, 0, 1};
    int len[7] = '{9, 3, 2, 9, 3, 2, 9};
    run(7, 1, 0);
    for (int i = 0; i < 7; i++) begin
      checks += 2;
      if (i >= lg.size() || lg[i] != exp[i]) begin errors++; $display("FAIL tick_ignore phase[%0d]: got %0d want %0d", i, (i < lg.size()) ? lg[i] : -1, exp[i]); end
      if (i >= plen.size() || plen[i] != len[i]) begin errors++; $display("FAIL tick_ignore cycles[%0d]: got %0d want %0d", i, (i < plen.size()) ? plen[i] : -1, len[i]); end
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b1);
    ped_req = 1'b0;
    checks += 2;
    if (phase !== 3'd1) begin errors++; $display("FAIL async pre phase: got %0d want 1", phase); end
    if (ped_pending !== 1'b1) begin errors++; $display("FAIL async pre ped_pending: got %b want 1", ped_pending); end
    #3 reset = 1'b1;
    #1;
    checks += 4;
    if (phase !== 3'd5) begin errors++; $display("FAIL async phase: got %0d want 5", phase); end
    if (ped_pending !== 1'b0) begin errors++; $display("FAIL async ped_pending: got %b want 0", ped_pending); end
    if (timer_reset !== 1'b1) begin errors++; $display("FAIL async timer_reset: got %b want 1", timer_reset); end
    if (ns_light !== 3'b100 || ew_light !== 3'b100) begin errors++; $display("FAIL async lamps: got %b/%b want 100/100", ns_light, ew_light); end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
  endtask

  task automatic test_params();
    logic [2:0] ph2[42];
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();
    t2 = 1'b1;
    for (int e = 1; e <= 41; e++) begin
      cycle(1'b0, 1'b0);
      ph2[e] = phase2;
    end
    t2 = 1'b0;
    checks += 9;
    if (ph2[16] !== 3'd5) begin errors++; $display("FAIL params red hold e16: got %0d want 5", ph2[16]); end
    if (ph2[17] !== 3'd0) begin errors++; $display("FAIL params red exit e17: got %0d want 0", ph2[17]); end
    if (ph2[18] !== 3'd0) begin errors++; $display("FAIL params green restart e18: got %0d want 0", ph2[18]); end
    if (ph2[19] !== 3'd1) begin errors++; $display("FAIL params green exit e19: got %0d want 1", ph2[19]); end
    if (ph2[21] !== 3'd1) begin errors++; $display("FAIL params yellow e21: got %0d want 1", ph2[21]); end
    if (ph2[22] !== 3'd2) begin errors++; $display("FAIL params yellow exit e22: got %0d want 2", ph2[22]); end
    if (ph2[38] !== 3'd2) begin errors++; $display("FAIL params red_a hold e38: got %0d want 2", ph2[38]); end
    if (ph2[39] !== 3'd3) begin errors++; $display("FAIL params red_a exit e39: got %0d want 3", ph2[39]); end
    if (ph2[41] !== 3'd4) begin errors++; $display("FAIL params ew green exit e41: got %0d want 4", ph2[41]); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_ped_walk();
    test_ped_hold();
    test_tick_ignore();
    test_async_reset();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/traffic_sequencer.md
# traffic_sequencer

Moore-style traffic-light controller that sequences a four-way intersection using the one-cycle tick `t` produced by the lab `Timer` block. It counts timer ticks to time each light phase, services a latched pedestrian request with an all-red walk phase, and restarts the `Timer` on every phase change so each phase begins on a fresh tick interval. It sits between the `Timer` instance and the board light/LED outputs.

## Interface
- `GREEN_TICKS`, default 8: ticks spent in each green phase.
- `YELLOW_TICKS`, default 2: ticks spent in each yellow phase.
- `RED_TICKS`, default 1: ticks spent in each all-red clearance phase.
- `WALK_TICKS`, default 4: ticks spent in the pedestrian walk phase.
- `CW`, default 4: tick-counter width. Every duration must satisfy 1 <= D <= 2^CW.

- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `t`  in  1  one-clock tick pulse from `Timer`.
- `ped_req`  in  1  pedestrian button, level or pulse, synchronous to `clock`.
- `ns_light`  out  3  north/south lamps {red, yellow, green}, one-hot.
- `ew_light`  out  3  east/west lamps {red, yellow, green}, one-hot.
- `walk`  out  1  pedestrian walk lamp.
- `ped_pending`  out  1  a pedestrian request is latched and not yet served.
- `timer_reset`  out  1  drives the `reset` input of `Timer`.
- `phase`  out  3  current state encoding, for debug and LEDs.

## Operation
- States and `phase` codes:
  - NS_GREEN = 0, NS_YELLOW = 1, RED_A = 2, EW_GREEN = 3, EW_YELLOW = 4, RED_B = 5, WALK = 6.
  - Code 7 is illegal and goes to RED_B on the next clock.
- Phase sequence and durations:
  - NS_GREEN (GREEN_TICKS) -> NS_YELLOW (YELLOW_TICKS) -> RED_A (RED_TICKS) -> EW_GREEN (GREEN_TICKS) -> EW_YELLOW (YELLOW_TICKS) -> RED_B (RED_TICKS).
  - Leaving RED_B: if `ped_pending`=1, go to WALK (WALK_TICKS), otherwise go to NS_GREEN.
  - WALK -> NS_GREEN.
- Tick counter `cnt` (CW bits):
  - Increments on each accepted tick.
  - An accepted tick is `t`=1 while `timer_reset`=0. `t` is ignored while `timer_reset`=1.
  - When an accepted tick arrives with `cnt` == D-1 for the current state: the state advances and `cnt` <- 0 on that same edge.
  - D=1 therefore advances on the first accepted tick. `cnt` never wraps.
- Lamp decode (combinational from the state register only):
  - NS_GREEN: ns=001, ew=100.
  - NS_YELLOW: ns=010, ew=100.
  - EW_GREEN: ns=100, ew=001.
  - EW_YELLOW: ns=100, ew=010.
  - RED_A, RED_B, WALK: ns=100, ew=100.
  - `walk`=1 only in WALK.
- Pedestrian latch:
  - `ped_pending` is set on any clock with `ped_req`=1, except while in WALK.
  - It is cleared on the edge that enters WALK. Clear wins over a simultaneous set.
  - `ped_req` during WALK is dropped.
  - A request arriving in the same cycle RED_B exits is not latched in time; it is served on the next cycle round.
- Timer restart:
  - `timer_reset` is a register. It is 1 for exactly the one cycle following every state transition, and 0 otherwise.

## Timing
- Reset (asynchronous, immediate) values:
  - state = RED_B, `phase`=5, `cnt`=0.
  - `ns_light`=100, `ew_light`=100, `walk`=0, `ped_pending`=0, `timer_reset`=1.
- Release of reset: `timer_reset` falls on the first rising edge after `reset` deasserts.
- Latency:
  - Lamps change in the same cycle the state register updates: the edge that samples the final tick.
  - `timer_reset` pulses in the next cycle.
  - `ped_pending` rises one edge after `ped_req` is sampled high.
- Reset mid-phase: returns to the reset values above regardless of state, `cnt` or pending request. Any pending request is lost.
- Minimum phase length is 2 cycles: the restart cycle plus one tick cycle.

## Test plan
- Reset, then `t` pulse every 4 cycles, default parameters -> `phase` runs 5,0,1,2,3,4,5,0. Each phase lasts its tick count: NS_GREEN sees 8 accepted ticks, yellow 2, red 1. `walk` stays 0.
- `ped_req` single-cycle pulse during EW_GREEN -> `ped_pending`=1 the next cycle. After RED_B, `phase`=6, `walk`=1, lamps 100/100, `ped_pending`=0. WALK lasts 4 ticks, then `phase`=0.
- `ped_req` held high through WALK -> no re-latch during WALK. Latched again the first cycle of NS_GREEN, so a second WALK follows the next RED_B.
- `t`=1 in the cycle `timer_reset`=1 after every transition -> tick ignored, `cnt` unchanged. Check that `timer_reset` is exactly 1 cycle wide after each of 7 transitions.
- Assert `reset` asynchronously between edges during NS_YELLOW with `ped_pending`=1 -> outputs take reset values immediately, before the next edge: `phase`=5, `ped_pending`=0, `timer_reset`=1.
- Parameters GREEN_TICKS=1, RED_TICKS=16, CW=4 -> green advances on its first accepted tick. Red holds for 16 ticks with `cnt` reaching 15 and no wrap.
